// File: rtl/tipi_bus_ctrl.sv
// TIPI register-window controller: synchronizes the TI-99/4A bus into clk,
// latches TI writes to TD/TC, gates TI reads of RD/RC and loads RD/RC serially.
module tipi_bus_ctrl #(
    parameter int          SETTLE_CYC = 3,
    parameter logic [15:0] TD_ADDR    = 16'h5FFF,
    parameter logic [15:0] TC_ADDR    = 16'h5FFD,
    parameter logic [15:0] RD_ADDR    = 16'h5FFB,
    parameter logic [15:0] RC_ADDR    = 16'h5FF9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [0:15] ti_a,
    input  logic [0:7]  ti_data,
    input  logic        ti_memen,
    input  logic        ti_we,
    input  logic        ti_dbin,
    input  logic        rpi_sclk,
    input  logic        rpi_sdata,
    input  logic        rpi_le,
    input  logic        rpi_sel,
    output logic [7:0]  td_q,
    output logic [7:0]  tc_q,
    output logic        td_wr,
    output logic        tc_wr,
    output logic [7:0]  ti_rdata,
    output logic        tipi_data_out,
    output logic        tipi_control_out
);

    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, WAIT_HI} state_t;

    state_t      r_state, w_state_nx;
    logic [2:0]  r_cnt, w_cnt_nx;
    logic        w_cap_td, w_cap_tc;

    logic        r_we_s1, r_we_s2, r_memen_s1, r_memen_s2, r_dbin_s1, r_dbin_s2;
    logic [15:0] r_a_s1, r_a_s2;
    logic [7:0]  r_data_s1, r_data_s2;
    logic        r_sclk_s1, r_sclk_s2, r_sdata_s1, r_sdata_s2;
    logic        r_le_s1, r_le_s2, r_sel_s1, r_sel_s2;
    logic        r_we_prev, r_sclk_prev, r_le_prev;
    logic [1:0]  r_flush;

    logic [7:0]  r_td_q, r_tc_q, r_rd, r_rc, r_shift, r_rdata;
    logic        r_td_wr, r_tc_wr, r_oe_d_n, r_oe_c_n;
    logic [3:0]  r_bits;

    logic        w_we_fall, w_hit_td, w_hit_tc, w_rd_sel, w_rc_sel;
    logic        w_sclk_rise, w_le_rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we_s1    <= 1'b1;
            r_we_s2    <= 1'b1;
            r_memen_s1 <= 1'b0;
            r_memen_s2 <= 1'b0;
            r_dbin_s1  <= 1'b0;
            r_dbin_s2  <= 1'b0;
            r_a_s1     <= '0;
            r_a_s2     <= '0;
            r_data_s1  <= '0;
            r_data_s2  <= '0;
            r_sclk_s1  <= 1'b0;
            r_sclk_s2  <= 1'b0;
            r_sdata_s1 <= 1'b0;
            r_sdata_s2 <= 1'b0;
            r_le_s1    <= 1'b0;
            r_le_s2    <= 1'b0;
            r_sel_s1   <= 1'b0;
            r_sel_s2   <= 1'b0;
        end else begin
            r_we_s1    <= ti_we;
            r_we_s2    <= r_we_s1;
            r_memen_s1 <= ti_memen;
            r_memen_s2 <= r_memen_s1;
            r_dbin_s1  <= ti_dbin;
            r_dbin_s2  <= r_dbin_s1;
            r_a_s1     <= ti_a;
            r_a_s2     <= r_a_s1;
            r_data_s1  <= ti_data;
            r_data_s2  <= r_data_s1;
            r_sclk_s1  <= rpi_sclk;
            r_sclk_s2  <= r_sclk_s1;
            r_sdata_s1 <= rpi_sdata;
            r_sdata_s2 <= r_sdata_s1;
            r_le_s1    <= rpi_le;
            r_le_s2    <= r_le_s1;
            r_sel_s1   <= rpi_sel;
            r_sel_s2   <= r_sel_s1;
        end
    end

    // The edge register only trusts the ti_we synchronizer once its reset-forced
    // 1s have flushed, so a write already low at reset release is never seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flush     <= '0;
            r_we_prev   <= 1'b0;
            r_sclk_prev <= 1'b0;
            r_le_prev   <= 1'b0;
        end else begin
            r_flush     <= {r_flush[0], 1'b1};
            r_we_prev   <= r_we_s2 & r_flush[1];
            r_sclk_prev <= r_sclk_s2;
            r_le_prev   <= r_le_s2;
        end
    end

    assign w_we_fall   = r_we_prev & ~r_we_s2;
    assign w_hit_td    = ~r_memen_s2 && (r_a_s2 == TD_ADDR);
    assign w_hit_tc    = ~r_memen_s2 && (r_a_s2 == TC_ADDR);
    assign w_rd_sel    = ~r_memen_s2 && r_dbin_s2 && (r_a_s2 == RD_ADDR);
    assign w_rc_sel    = ~r_memen_s2 && r_dbin_s2 && (r_a_s2 == RC_ADDR) && !w_rd_sel;
    assign w_sclk_rise = r_sclk_s2 & ~r_sclk_prev;
    assign w_le_rise   = r_le_s2 & ~r_le_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_cap_td   = 1'b0;
        w_cap_tc   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_we_fall) begin
                    w_state_nx = SETTLE;
                    w_cnt_nx   = 3'(SETTLE_CYC - 1);
                end
            end
            SETTLE: begin
                if (r_cnt == 3'd0) w_state_nx = CAPTURE;
                else               w_cnt_nx   = r_cnt - 3'd1;
            end
            CAPTURE: begin
                w_cap_td   = w_hit_td;
                w_cap_tc   = w_hit_tc && !w_hit_td;
                w_state_nx = WAIT_HI;
            end
            WAIT_HI: begin
                if (r_we_s2) w_state_nx = IDLE;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_td_q  <= '0;
            r_tc_q  <= '0;
            r_td_wr <= 1'b0;
            r_tc_wr <= 1'b0;
        end else begin
            r_td_wr <= w_cap_td;
            r_tc_wr <= w_cap_tc;
            if (w_cap_td) r_td_q <= r_data_s2;
            if (w_cap_tc) r_tc_q <= r_data_s2;
        end
    end

    // A simultaneous le edge closes the current frame before the sclk bit opens the next.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
            r_bits  <= '0;
            r_rd    <= '0;
            r_rc    <= '0;
        end else begin
            if (w_le_rise) begin
                if (r_bits == 4'd8) begin
                    if (r_sel_s2) r_rc <= r_shift;
                    else          r_rd <= r_shift;
                end
                r_bits <= w_sclk_rise ? 4'd1 : 4'd0;
            end else if (w_sclk_rise) begin
                r_bits <= (r_bits == 4'd8) ? 4'd8 : r_bits + 4'd1;
            end
            if (w_sclk_rise) r_shift <= {r_shift[6:0], r_sdata_s2};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_oe_d_n <= 1'b1;
            r_oe_c_n <= 1'b1;
            r_rdata  <= '0;
        end else begin
            r_oe_d_n <= ~w_rd_sel;
            r_oe_c_n <= ~w_rc_sel;
            r_rdata  <= w_rc_sel ? r_rc : r_rd;
        end
    end

    assign td_q             = r_td_q;
    assign tc_q             = r_tc_q;
    assign td_wr            = r_td_wr;
    assign tc_wr            = r_tc_wr;
    assign ti_rdata         = r_rdata;
    assign tipi_data_out    = r_oe_d_n;
    assign tipi_control_out = r_oe_c_n;

endmodule

// File: tb/tb_tipi_bus_ctrl.sv
// Self-checking bench for tipi_bus_ctrl: directed and random TI writes, TI reads
// and RPi serial frames checked against a register-level model of the window.
module tb_tipi_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [0:15] ti_a = '0;
    logic [0:7]  ti_data = '0;
    logic        ti_memen = 1'b1;
    logic        ti_we = 1'b1;
    logic        ti_dbin = 1'b0;
    logic        rpi_sclk = 1'b0;
    logic        rpi_sdata = 1'b0;
    logic        rpi_le = 1'b0;
    logic        rpi_sel = 1'b0;
    logic [7:0]  td_q, tc_q, ti_rdata;
    logic        td_wr, tc_wr, tipi_data_out, tipi_control_out;

    int total = 0;
    int bad   = 0;

    // reference model of the programmer-visible registers
    logic [7:0] m_td = '0, m_tc = '0, m_rd = '0, m_rc = '0;
    logic [7:0] m_shift = '0;
    int         m_bits = 0;

    tipi_bus_ctrl #(.SETTLE_CYC(3)) dut (
        .clk(clk), .rst(rst), .ti_a(ti_a), .ti_data(ti_data), .ti_memen(ti_memen),
        .ti_we(ti_we), .ti_dbin(ti_dbin), .rpi_sclk(rpi_sclk), .rpi_sdata(rpi_sdata),
        .rpi_le(rpi_le), .rpi_sel(rpi_sel), .td_q(td_q), .tc_q(tc_q), .td_wr(td_wr),
        .tc_wr(tc_wr), .ti_rdata(ti_rdata), .tipi_data_out(tipi_data_out),
        .tipi_control_out(tipi_control_out)
    );

    always #10 clk = ~clk;

    task automatic ti_write(input logic [15:0] addr, input logic [7:0] data, input logic memen,
                            output int ntd, output int ntc, output int first);
        ntd = 0; ntc = 0; first = -1;
        @(negedge clk);
        ti_a = addr; ti_data = data; ti_memen = memen;
        repeat (2) @(negedge clk);
        ti_we = 1'b0;
        for (int c = 1; c <= 21; c++) begin
            @(negedge clk);
            if (td_wr === 1'b1) begin ntd++; if (first < 0) first = c; end
            if (tc_wr === 1'b1) begin ntc++; if (first < 0) first = c; end
            if (c == 15) begin ti_we = 1'b1; ti_memen = 1'b1; end
        end
        if (!memen && addr == 16'h5FFF) m_td = data;
        else if (!memen && addr == 16'h5FFD) m_tc = data;
    endtask

    task automatic check_write(input string name, input logic [15:0] addr, input logic [7:0] data,
                               input logic memen);
        int ntd, ntc, first, etd, etc;
        etd = (!memen && addr == 16'h5FFF) ? 1 : 0;
        etc = (!memen && addr == 16'h5FFD) ? 1 : 0;
        ti_write(addr, data, memen, ntd, ntc, first);
        total += 4;
        if (td_q !== m_td) begin bad++; $display("FAIL %s td_q got=%h exp=%h", name, td_q, m_td); end
        if (tc_q !== m_tc) begin bad++; $display("FAIL %s tc_q got=%h exp=%h", name, tc_q, m_tc); end
        if (ntd !== etd) begin bad++; $display("FAIL %s td_wr pulses got=%0d exp=%0d", name, ntd, etd); end
        if (ntc !== etc) begin bad++; $display("FAIL %s tc_wr pulses got=%0d exp=%0d", name, ntc, etc); end
        if (etd + etc > 0) begin
            total++;
            if (first !== 7) begin bad++; $display("FAIL %s strobe latency got=%0d exp=7", name, first); end
        end
    endtask

    task automatic rpi_send(input logic [15:0] value, input int n, input logic sel);
        rpi_sel = sel;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rpi_sdata = value[n-1-i];
            repeat (3) @(negedge clk);
            rpi_sclk = 1'b1;
            repeat (3) @(negedge clk);
            rpi_sclk = 1'b0;
            m_shift = 8'(((m_shift << 1) | value[n-1-i]) & 8'hFF);
            if (m_bits < 8) m_bits++;
        end
        repeat (3) @(negedge clk);
        rpi_le = 1'b1;
        repeat (3) @(negedge clk);
        rpi_le = 1'b0;
        repeat (3) @(negedge clk);
        if (m_bits == 8) begin
            if (sel) m_rc = m_shift; else m_rd = m_shift;
        end
        m_bits = 0;
    endtask

    task automatic ti_read(input string name, input logic [15:0] addr);
        logic exp_d, exp_c;
        logic [7:0] exp_r;
        exp_d = (addr == 16'h5FFB) ? 1'b0 : 1'b1;
        exp_c = (addr == 16'h5FF9) ? 1'b0 : 1'b1;
        exp_r = (exp_c == 1'b0) ? m_rc : m_rd;
        @(negedge clk);
        ti_a = addr; ti_memen = 1'b0; ti_dbin = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 2) begin
                total++;
                if (tipi_data_out !== 1'b1 || tipi_control_out !== 1'b1) begin
                    bad++;
                    $display("FAIL %s early OE got=%b%b exp=11", name, tipi_data_out, tipi_control_out);
                end
            end
        end
        total += 3;
        if (tipi_data_out !== exp_d) begin bad++; $display("FAIL %s data_oe got=%b exp=%b", name, tipi_data_out, exp_d); end
        if (tipi_control_out !== exp_c) begin bad++; $display("FAIL %s ctrl_oe got=%b exp=%b", name, tipi_control_out, exp_c); end
        if (ti_rdata !== exp_r) begin bad++; $display("FAIL %s ti_rdata got=%h exp=%h", name, ti_rdata, exp_r); end
        ti_memen = 1'b1; ti_dbin = 1'b0;
        repeat (4) @(negedge clk);
        total++;
        if (tipi_data_out !== 1'b1 || tipi_control_out !== 1'b1) begin
            bad++;
            $display("FAIL %s OE release got=%b%b exp=11", name, tipi_data_out, tipi_control_out);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        total++;
        if (td_q !== 8'h00 || tc_q !== 8'h00 || ti_rdata !== 8'h00 || td_wr !== 1'b0 ||
            tc_wr !== 1'b0 || tipi_data_out !== 1'b1 || tipi_control_out !== 1'b1) begin
            bad++;
            $display("FAIL %s reset outputs got td=%h tc=%h rdata=%h wr=%b%b oe=%b%b exp 00 00 00 00 11",
                     name, td_q, tc_q, ti_rdata, td_wr, tc_wr, tipi_data_out, tipi_control_out);
        end
    endtask

    task automatic test_reset();
        int ntd = 0;
        rst = 1'b1; ti_we = 1'b0;
        repeat (4) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        ti_a = 16'h5FFF; ti_data = 8'hA5; ti_memen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (td_wr === 1'b1) ntd++;
        end
        total += 2;
        if (ntd !== 0) begin bad++; $display("FAIL reset_we_low td_wr pulses got=%0d exp=0", ntd); end
        if (td_q !== 8'h00) begin bad++; $display("FAIL reset_we_low td_q got=%h exp=00", td_q); end
        ti_we = 1'b1; ti_memen = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_write();
        check_write("wr_td_a5", 16'h5FFF, 8'hA5, 1'b0);
        check_write("wr_tc_3c", 16'h5FFD, 8'h3C, 1'b0);
    endtask

    task automatic test_no_write();
        check_write("wr_5ffe", 16'h5FFE, 8'h77, 1'b0);
        check_write("wr_memen_hi", 16'h5FFF, 8'h11, 1'b1);
    endtask

    task automatic test_random_writes();
        logic [15:0] addr;
        for (int i = 0; i < 16; i++) begin
            case ($urandom_range(0, 3))
                0: addr = 16'h5FFF;
                1: addr = 16'h5FFD;
                2: addr = 16'h5FFE;
                default: addr = 16'($urandom);
            endcase
            check_write("wr_rand", addr, 8'($urandom), ($urandom_range(0, 4) == 0));
        end
    endtask

    task automatic test_rpi_read();
        rpi_send(16'h005A, 8, 1'b0);
        ti_read("rd_5ffb", 16'h5FFB);
        ti_read("rd_5ff9", 16'h5FF9);
        ti_read("rd_other", 16'h5FFF);
    endtask

    task automatic test_rpi_frames();
        rpi_send(16'h007F, 7, 1'b0);
        ti_read("short_rd", 16'h5FFB);
        ti_read("short_rc", 16'h5FF9);
        rpi_send(16'h02C3, 10, 1'b1);
        ti_read("long_rc", 16'h5FF9);
        for (int i = 0; i < 10; i++) begin
            rpi_send(16'($urandom), $urandom_range(6, 11), 1'($urandom));
            ti_read("rand_rd", 16'h5FFB);
            ti_read("rand_rc", 16'h5FF9);
        end
    endtask

    task automatic test_reset_settle();
        int ntd = 0;
        rpi_send(16'h0096, 8, 1'b0);
        @(negedge clk);
        ti_a = 16'h5FFF; ti_data = 8'hC7; ti_memen = 1'b0;
        repeat (2) @(negedge clk);
        ti_we = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (td_wr === 1'b1) ntd++;
        end
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset_settle");
        m_td = '0; m_tc = '0; m_rd = '0; m_rc = '0; m_shift = '0; m_bits = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (td_wr === 1'b1) ntd++;
        end
        total += 2;
        if (ntd !== 0) begin bad++; $display("FAIL reset_settle td_wr pulses got=%0d exp=0", ntd); end
        if (td_q !== 8'h00) begin bad++; $display("FAIL reset_settle td_q got=%h exp=00", td_q); end
        ti_we = 1'b1; ti_memen = 1'b1;
        repeat (4) @(negedge clk);
        ti_read("post_rst_rd", 16'h5FFB);
        check_write("post_rst_wr", 16'h5FFF, 8'h5C, 1'b0);
    endtask

    initial begin
        test_reset();
        test_write();
        test_no_write();
        test_random_writes();
        test_rpi_read();
        test_rpi_frames();
        test_reset_settle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tipi_bus_ctrl.md
# tipi_bus_ctrl

Clock-domain controller for the TIPI register window. It samples the asynchronous TI-99/4A bus with the 50 MHz system clock and sequences TI writes into the TD (0x5FFF) and TC (0x5FFD) latches. It gates TI reads of the RPi-owned RD (0x5FFB) and RC (0x5FF9) registers through the output-enable transmitters. It also loads RD/RC from a simple RPi serial link. It sits between the TI edge-connector pins and the rpi_d/rpi_s outputs of the top level.

## Interface
Parameters:
- SETTLE_CYC, 3: clk cycles waited after the detected TI write strobe before TI address/data are captured (1..7).
- TD_ADDR, 16'h5FFF: TI → RPi data register address.
- TC_ADDR, 16'h5FFD: TI → RPi control register address.
- RD_ADDR, 16'h5FFB: RPi → TI data register address.
- RC_ADDR, 16'h5FF9: RPi → TI control register address.

Ports:
- clk  in  1  50 MHz system clock; the block's only clock.
- rst  in  1  reset; synchronous, active-high.
- ti_a  in  [0:15]  TI address; bit 0 is the MSB; asynchronous.
- ti_data  in  [0:7]  TI data bus; bit 0 is the MSB; asynchronous.
- ti_memen  in  1  TI memory enable; active low.
- ti_we  in  1  TI write enable; active low.
- ti_dbin  in  1  TI memory read; active high.
- rpi_sclk  in  1  RPi shift clock; the block shifts on its rising edge.
- rpi_sdata  in  1  RPi serial data; MSB first.
- rpi_le  in  1  RPi latch enable; the block loads on its rising edge.
- rpi_sel  in  1  RPi load target: 0 = RD, 1 = RC.
- td_q  out  8  TD latch; drives rpi_d.
- tc_q  out  8  TC latch; drives rpi_s.
- td_wr  out  1  one-cycle pulse when TD is written.
- tc_wr  out  1  one-cycle pulse when TC is written.
- ti_rdata  out  8  data presented to the TI read transmitter: RD or RC.
- tipi_data_out  out  1  OE* of the RD transmitter; active low.
- tipi_control_out  out  1  OE* of the RC transmitter; active low.

## Operation
- Every asynchronous input passes through a 2-FF synchronizer: ti_we, ti_memen, ti_dbin, ti_a, ti_data and all rpi_* inputs.
- The reset value of the ti_we synchronizer stages is 1. The reset value of the rpi_sclk and rpi_le stages is 0.
- Write FSM states: IDLE, SETTLE, CAPTURE, WAIT_HI.
  - IDLE → SETTLE on a synchronized ti_we falling edge (previous sample 1, current sample 0). The settle counter loads SETTLE_CYC−1.
  - SETTLE decrements the counter each cycle. It moves to CAPTURE when the counter is 0.
  - CAPTURE lasts one cycle:
    - if synced memen = 0 and synced addr = TD_ADDR: td_q ← synced data (bit 0 → td_q[7]) and td_wr = 1;
    - else if synced memen = 0 and synced addr = TC_ADDR: the same for tc_q / tc_wr;
    - otherwise nothing is captured.
  - CAPTURE → WAIT_HI.
  - WAIT_HI → IDLE once synced ti_we = 1.
- A ti_we that returns high during SETTLE still proceeds to CAPTURE. The captured values are whatever is synced at that cycle.
- Read gating:
  - tipi_data_out is registered, and equals 0 iff synced memen = 0, dbin = 1 and addr = RD_ADDR. tipi_control_out is registered in the same way for RC_ADDR.
  - Both outputs are never 0 at the same time.
  - ti_rdata = RC when tipi_control_out = 0, otherwise RD. ti_rdata is registered.
- RPi link:
  - On each synced rpi_sclk rising edge: shift ← {shift[6:0], rpi_sdata}, and the bit count increments, saturating at 8. Extra bits keep shifting, so the last 8 bits win.
  - On a synced rpi_le rising edge: if count = 8, load shift into RD (rpi_sel = 0) or RC (rpi_sel = 1). In all cases, count ← 0.
  - If an sclk edge and an le edge occur in the same cycle, the le edge is processed first; the sclk bit starts the next frame with count = 1.
- A load of RD/RC while the TI is reading that register updates ti_rdata on the next cycle.
- Reset (at any point, including mid-write): the FSM goes to IDLE and every register clears.
  - A TI write already in progress when reset is released is not captured, because ti_we must first be seen high.

## Timing
- Reset values: td_q = tc_q = RD = RC = ti_rdata = 8'h00; td_wr = tc_wr = 0; tipi_data_out = tipi_control_out = 1.
- Write latency: ti_we pin fall → FSM leaves IDLE after 3 clk (2 sync + edge register). CAPTURE follows SETTLE_CYC cycles later. td_q/td_wr update the cycle after CAPTURE.
  - With the default SETTLE_CYC = 3, td_q updates 7 clk (140 ns) after the pin falls. This must be less than the TI minimum WE* low time.
- td_wr/tc_wr are high for exactly 1 cycle per TI write.
- Read OE*: asserts and deasserts 3 clk after the qualifying pin changes.
- RPi link: minimum rpi_sclk high and low times are 3 clk each. rpi_le must rise at least 3 clk after the last sclk rise.

## Test plan
- Reset with ti_we held low, release reset, then assert memen = 0, addr 5FFF, data A5 and keep ti_we low → td_q stays 00 and td_wr never pulses.
- TI write 5FFF = A5 (WE* low 300 ns) → td_q = A5, one td_wr pulse 7 clk after the WE* fall, tc_q unchanged. Then write 5FFD = 3C → tc_q = 3C, one tc_wr pulse.
- TI write to 5FFE, or with memen = 1 → no latch change, no strobe pulse.
- RPi shifts 8 bits 0x5A with sel = 0, then le → RD = 5A. TI read at 5FFB → tipi_data_out = 0 and ti_rdata = 5A. TI read at 5FF9 → tipi_control_out = 0 and ti_rdata = RC.
- RPi shifts 7 bits, then le → RD/RC unchanged. RPi shifts 10 bits ending in 0xC3, then le with sel = 1 → RC = C3.
- Assert rst during SETTLE → FSM goes to IDLE, no td_wr pulse, all outputs at reset values on the next cycle.
